// File: rtl/sr_ff_bank.sv
// sr_ff_bank: bank of WIDTH clocked SR flags with common enable,
// MODE-selected S=R=1 resolution, per-bit conflict flags and a
// saturating conflict counter. Sync active-high reset.
// Ports: clk, rst, en, s[W], r[W], cnt_clr -> q[W], qn[W],
//   conflict[W], conflict_cnt[CNT_W].
// Optional (SR_FF_BANK_EDGE_DET_EN): q_rise[W], q_fall[W].
module sr_ff_bank #(
  parameter int               WIDTH = 8,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
`ifdef SR_FF_BANK_EDGE_DET_EN
  ,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall
`endif
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qn_q;
  logic [WIDTH-1:0] conf_q, conf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] both;

  assign both = s & r;

  always_comb begin
    q_d = q_q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case ({s[i], r[i]})
          2'b10: q_d[i] = 1'b1;
          2'b01: q_d[i] = 1'b0;
          2'b11: begin
            // S=R=1 resolution; unknown MODE falls back to clear
            unique case (MODE)
              1:       q_d[i] = 1'b1;
              2:       q_d[i] = q_q[i];
              3:       q_d[i] = ~q_q[i];
              default: q_d[i] = 1'b0;
            endcase
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end
  end

  always_comb begin
    conf_d = '0;
    if (en) conf_d = both;
  end

  // clear beats increment; one step per cycle, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (en && (|both) && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= INIT;
      qn_q   <= ~INIT;
      conf_q <= '0;
      cnt_q  <= '0;
    end else begin
      q_q    <= q_d;
      qn_q   <= ~q_d;
      conf_q <= conf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q            = q_q;
  assign qn           = qn_q;
  assign conflict     = conf_q;
  assign conflict_cnt = cnt_q;

`ifdef SR_FF_BANK_EDGE_DET_EN
  logic [WIDTH-1:0] dly_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // delayed copy starts at INIT so no pulse right after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q  <= INIT;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      dly_q  <= q_q;
      rise_q <= q_q & ~dly_q;
      fall_q <= ~q_q & dly_q;
    end
  end

  assign q_rise = rise_q;
  assign q_fall = fall_q;
`endif

endmodule
